// File: rtl/node_controller_if.sv
// -----------------------------------------------------------------------------
// node_controller_if
// Bundles the scheduler/node-facing signals of one node_controller.
//   go, abort, in_valid : requests and upstream status into the controller
//   node_out            : activated output returned by the node
//   start, reset_acc    : accumulator controls driven to the node
//   cnt_val             : MAC term index driven to the node
//   busy, done, result  : status and captured output back to the scheduler
// The master modport is the environment (scheduler + node); the slave
// modport is the controller itself.
// -----------------------------------------------------------------------------
interface node_controller_if #(
   parameter int OUT_WIDTH = 16
);
   logic                 go;
   logic                 abort;
   logic                 in_valid;
   logic [OUT_WIDTH-1:0] node_out;
   logic                 start;
   logic                 reset_acc;
   logic [6:0]           cnt_val;
   logic                 busy;
   logic                 done;
   logic [OUT_WIDTH-1:0] result;

   modport master (
      output go, abort, in_valid, node_out,
      input  start, reset_acc, cnt_val, busy, done, result
   );

   modport slave (
      input  go, abort, in_valid, node_out,
      output start, reset_acc, cnt_val, busy, done, result
   );
endinterface

// File: rtl/node_controller.sv
// -----------------------------------------------------------------------------
// node_controller
// Sequences one neural-network node through a full inference: clear the
// accumulator, step through IMAGE_SIZE multiply-accumulate terms (stalling
// while upstream data is not valid), capture the activated output into
// result and pulse done.
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : node_controller_if slave port (go/abort/in_valid/node_out in,
//           start/reset_acc/cnt_val/busy/done/result out)
// -----------------------------------------------------------------------------
module node_controller #(
   parameter int IMAGE_SIZE = 64,
   parameter int OUT_WIDTH  = 16
) (
   input logic              clk,
   input logic              n_rst,
   node_controller_if.slave bus
);

   localparam logic [6:0] LAST_TERM = 7'(IMAGE_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      ACCUM   = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [6:0]           k_q, k_d;
   logic [OUT_WIDTH-1:0] result_q, result_d;

   logic                 start_s;
   logic                 reset_acc_s;
   logic [6:0]           cnt_val_s;
   logic                 busy_s;
   logic                 done_s;

   // State, term counter and captured result registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         k_q      <= 7'd0;
         result_q <= {OUT_WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         result_q <= result_d;
      end
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      result_d    = result_q;
      start_s     = 1'b1;
      reset_acc_s = 1'b0;
      cnt_val_s   = 7'd0;
      busy_s      = 1'b1;
      done_s      = 1'b0;

      case (state_q)
         IDLE: begin
            busy_s = 1'b0;
            k_d    = 7'd0;
            // abort takes priority over a simultaneous go
            if (bus.go && !bus.abort) begin
               state_d = CLEAR;
            end else begin
               state_d = IDLE;
            end
         end

         CLEAR: begin
            reset_acc_s = 1'b1;
            k_d         = 7'd0;
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               state_d = ACCUM;
            end
         end

         ACCUM: begin
            // start is active-low "accumulate": a missing term freezes the node
            start_s   = !bus.in_valid;
            cnt_val_s = k_q;
            if (bus.abort) begin
               state_d = IDLE;
               k_d     = 7'd0;
            end else if (bus.in_valid) begin
               if (k_q == LAST_TERM) begin
                  state_d = CAPTURE;
                  k_d     = 7'd0;
               end else begin
                  state_d = ACCUM;
                  k_d     = k_q + 7'd1;
               end
            end else begin
               state_d = ACCUM;
               k_d     = k_q;
            end
         end

         CAPTURE: begin
            // node_out is stable here because start holds the accumulator
            if (bus.abort) begin
               state_d = IDLE;
            end else begin
               state_d  = DONE;
               result_d = bus.node_out;
            end
         end

         DONE: begin
            done_s  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            k_d     = 7'd0;
         end
      endcase
   end

   assign bus.start     = start_s;
   assign bus.reset_acc = reset_acc_s;
   assign bus.cnt_val   = cnt_val_s;
   assign bus.busy      = busy_s;
   assign bus.done      = done_s;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_node_controller.sv
// -----------------------------------------------------------------------------
// tb_node_controller
// Self-checking bench for node_controller. dut1 uses IMAGE_SIZE=64 and is
// attached to a behavioural node (accumulator of coef*data) or a constant
// stub; dut2 uses IMAGE_SIZE=1 with a constant stub.
// -----------------------------------------------------------------------------
module tb_node_controller;

   localparam int N = 64;

   logic clk = 1'b0;
   logic n_rst;

   always #5 clk = ~clk;

   node_controller_if #(.OUT_WIDTH(16)) bus1 ();
   node_controller_if #(.OUT_WIDTH(16)) bus2 ();

   node_controller #(.IMAGE_SIZE(N), .OUT_WIDTH(16)) dut1 (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus1.slave)
   );

   node_controller #(.IMAGE_SIZE(1), .OUT_WIDTH(16)) dut2 (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus2.slave)
   );

   // behavioural node for dut1
   logic [15:0] coef [0:127];
   logic [15:0] data [0:127];
   logic [15:0] acc = 16'd0;
   logic        use_stub;

   always @(posedge clk) begin
      if (bus1.reset_acc) acc <= 16'd0;
      else if (!bus1.start) acc <= acc + coef[bus1.cnt_val] * data[bus1.cnt_val];
   end

   assign bus1.node_out = use_stub ? 16'hA5A5 : acc;
   assign bus2.node_out = 16'h1234;

   int          checks = 0;
   int          errors = 0;
   bit          vld [0:599];
   logic [15:0] last_result;

   // Reference sum of all IMAGE_SIZE products, mod 2^16.
   function automatic logic [15:0] ref_sum();
      logic [15:0] s = 16'd0;
      for (int k = 0; k < N; k++) s = s + coef[k] * data[k];
      return s;
   endfunction

   // Expected done cycle from the in_valid pattern: 2 + N + stalled ACCUM cycles.
   function automatic int ref_done_cycle();
      int got = 0;
      int c = 1;
      while (got < N) begin
         if (vld[c]) got++;
         c++;
      end
      return c + 1;
   endfunction

   // Drives one run on dut1 using vld[] (indexed by cycle after E0) and checks
   // every cycle's outputs against the timeline the spec defines.
   task automatic do_run(input string name, input logic [15:0] exp_result, output int done_cycle);
      int   m = 0;
      int   cap_c = -1;
      bit   fin = 1'b0;
      logic [10:0] exp_o;
      logic [10:0] got_o;
      logic exp_start, exp_rst, exp_busy, exp_done;
      logic [6:0] exp_cnt;
      done_cycle = -1;
      bus1.go = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 600 && !fin; c++) begin
         if (c > 0) @(posedge clk);
         #1;
         bus1.go       = 1'b0;
         bus1.in_valid = vld[c];
         #1;
         exp_start = 1'b1; exp_rst = 1'b0; exp_cnt = 7'd0; exp_busy = 1'b1; exp_done = 1'b0;
         if (c == 0) exp_rst = 1'b1;
         else if (cap_c < 0) begin
            exp_start = !vld[c];
            exp_cnt   = 7'(m);
         end else if (c == cap_c + 1) exp_done = 1'b1;
         else if (c == cap_c + 2) exp_busy = 1'b0;
         exp_o = {exp_start, exp_rst, exp_cnt, exp_busy, exp_done};
         got_o = {bus1.start, bus1.reset_acc, bus1.cnt_val, bus1.busy, bus1.done};
         checks++;
         if (got_o !== exp_o) begin
            errors++;
            $display("FAIL %s outputs c=%0d got start/rst/cnt/busy/done=%b exp %b", name, c, got_o, exp_o);
         end
         if (exp_done) begin
            done_cycle = c;
            checks++;
            if (bus1.result !== exp_result) begin
               errors++;
               $display("FAIL %s result got %h exp %h", name, bus1.result, exp_result);
            end
         end
         if (c > 0 && cap_c < 0 && vld[c]) begin
            m++;
            if (m == N) cap_c = c + 1;
         end
         if (cap_c >= 0 && c == cap_c + 2) fin = 1'b1;
      end
      bus1.in_valid = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL %s timeout got no completion exp completion", name);
      end
      last_result = exp_result;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      bus1.go = 1'b0; bus1.abort = 1'b0; bus1.in_valid = 1'b0;
      bus2.go = 1'b0; bus2.abort = 1'b0; bus2.in_valid = 1'b0;
      use_stub = 1'b1;
      for (int k = 0; k < 128; k++) begin coef[k] = 16'd0; data[k] = 16'd0; end
      #22;
      checks++;
      if ({bus1.start, bus1.reset_acc, bus1.cnt_val, bus1.busy, bus1.done, bus1.result} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL reset_in outputs got %b/%b/%0d/%b/%b/%h", bus1.start, bus1.reset_acc, bus1.cnt_val, bus1.busy, bus1.done, bus1.result);
      end
      @(negedge clk);
      n_rst = 1'b1;
      @(posedge clk); #2;
      checks++;
      if ({bus1.start, bus1.reset_acc, bus1.cnt_val, bus1.busy, bus1.done, bus1.result, bus2.busy, bus2.result} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0}) begin
         errors++;
         $display("FAIL reset_out outputs got busy=%b done=%b result=%h busy2=%b", bus1.busy, bus1.done, bus1.result, bus2.busy);
      end
      last_result = 16'd0;
   endtask

   task automatic test_nominal();
      int dc;
      use_stub = 1'b1;
      for (int c = 0; c < 600; c++) vld[c] = 1'b1;
      do_run("nominal", 16'hA5A5, dc);
      checks++;
      if (dc !== 66) begin
         errors++;
         $display("FAIL nominal_done_edge got %0d exp 66", dc);
      end
   endtask

   task automatic test_stall();
      int dc;
      use_stub = 1'b0;
      for (int k = 0; k < 128; k++) begin coef[k] = 16'd1; data[k] = 16'd1; end
      for (int c = 0; c < 600; c++) vld[c] = 1'b1;
      do_run("unstalled", 16'd64, dc);
      // term 10 is presented in cycle 11
      vld[11] = 1'b0; vld[12] = 1'b0; vld[13] = 1'b0;
      do_run("stalled", 16'd64, dc);
      checks++;
      if (dc !== 69) begin
         errors++;
         $display("FAIL stall_done_edge got %0d exp 69", dc);
      end
   endtask

   task automatic test_abort();
      int  dc;
      bit  seen = 1'b0;
      bit  done_seen = 1'b0;
      bus1.go = 1'b1; bus1.in_valid = 1'b1;
      @(posedge clk); #2;
      bus1.go = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         if (bus1.cnt_val == 7'd20) seen = 1'b1;
         else begin @(posedge clk); #2; end
      end
      bus1.abort = 1'b1;
      @(posedge clk); #1;
      bus1.abort = 1'b0;
      #1;
      checks++;
      if (!seen || {bus1.start, bus1.reset_acc, bus1.cnt_val, bus1.busy, bus1.done} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL abort_idle got seen=%b busy=%b cnt=%0d exp busy=0 cnt=0", seen, bus1.busy, bus1.cnt_val);
      end
      for (int c = 0; c < 80; c++) begin
         if (bus1.done || bus1.busy) done_seen = 1'b1;
         @(posedge clk); #2;
      end
      checks++;
      if (done_seen || bus1.result !== last_result) begin
         errors++;
         $display("FAIL abort_quiet got done/busy_seen=%b result=%h exp 0 and %h", done_seen, bus1.result, last_result);
      end
      bus1.in_valid = 1'b0;
      for (int c = 0; c < 600; c++) vld[c] = 1'b1;
      do_run("after_abort", ref_sum(), dc);
   endtask

   task automatic test_go_abort_idle();
      bit moved = 1'b0;
      bus1.go = 1'b1; bus1.abort = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         if (bus1.busy || bus1.reset_acc) moved = 1'b1;
      end
      bus1.go = 1'b0; bus1.abort = 1'b0;
      checks++;
      if (moved) begin
         errors++;
         $display("FAIL go_abort_idle got left IDLE exp stays IDLE");
      end
   endtask

   task automatic test_back_to_back();
      int t1 = -1;
      int t2 = -1;
      use_stub = 1'b1;
      bus1.in_valid = 1'b1;
      bus1.go = 1'b1;
      for (int c = 0; c < 300 && t2 < 0; c++) begin
         @(posedge clk); #2;
         if (bus1.done) begin
            if (t1 < 0) t1 = c;
            else t2 = c;
         end
      end
      bus1.go = 1'b0;
      checks++;
      if (t1 !== 66 || t2 - t1 !== 68) begin
         errors++;
         $display("FAIL back_to_back got first=%0d period=%0d exp 66 and 68", t1, t2 - t1);
      end
      for (int c = 0; c < 100 && bus1.busy; c++) begin @(posedge clk); #2; end
      bus1.in_valid = 1'b0;
      last_result = 16'hA5A5;
   endtask

   task automatic test_random();
      int dc;
      use_stub = 1'b0;
      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < 128; k++) begin
            coef[k] = 16'($urandom_range(0, 15));
            data[k] = 16'($urandom_range(0, 15));
         end
         for (int c = 0; c < 600; c++) vld[c] = ($urandom_range(0, 3) != 0);
         do_run("random", ref_sum(), dc);
         checks++;
         if (dc !== ref_done_cycle()) begin
            errors++;
            $display("FAIL random_done_edge got %0d exp %0d", dc, ref_done_cycle());
         end
      end
   endtask

   task automatic test_image_size_one();
      bit bad = 1'b0;
      bus2.go = 1'b1;
      @(posedge clk); #1;
      bus2.go = 1'b0; bus2.in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin @(posedge clk); #2; end else #1;
         if (bus2.done !== (c == 3)) bad = 1'b1;
         if (c == 3 && bus2.result !== 16'h1234) bad = 1'b1;
      end
      bus2.in_valid = 1'b0;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL size_one got done/result mismatch exp done at E3 with 1234");
      end
   endtask

   task automatic test_async_reset();
      use_stub = 1'b1;
      bus1.in_valid = 1'b1; bus1.go = 1'b1;
      @(posedge clk); #1 bus1.go = 1'b0;
      repeat (30) @(posedge clk);
      #3 n_rst = 1'b0;
      #1;
      checks++;
      if ({bus1.start, bus1.reset_acc, bus1.cnt_val, bus1.busy, bus1.done, bus1.result, bus2.result} !== {1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
         errors++;
         $display("FAIL async_reset got start=%b cnt=%0d busy=%b result=%h result2=%h", bus1.start, bus1.cnt_val, bus1.busy, bus1.result, bus2.result);
      end
      @(negedge clk);
      n_rst = 1'b1;
      bus1.in_valid = 1'b0;
      @(posedge clk); #2;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_stall();
      test_abort();
      test_go_abort_idle();
      test_back_to_back();
      test_random();
      test_image_size_one();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
